sseg_scan: RTL and testbench
============================

SSEG_SCAN -- requirements
Module: sseg_scan

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: clk frequency in Hz.
REQ-002 SHALL have parameter SCAN_HZ, default 1000: per-digit dwell rate; dwell length DWELL = CLK_HZ/SCAN_HZ cycles, minimum 2.
REQ-003 SHALL have port clk  input  1  system clock; the block has one clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port load  input  1  request to latch new display content this cycle.
REQ-006 SHALL have port digits_in  input  24  six BCD digits; [23:20] is position 0 (leftmost), [3:0] is position 5.
REQ-007 SHALL have port dp_in  input  6  decimal-point enables; bit 5 is position 0, bit 0 is position 5; 1 = lit.
REQ-008 SHALL have port digit  output  5  to decoder: [4] = dp lit, [3:0] = BCD value.
REQ-009 SHALL have port digit_pos  output  3  active position 0..5, to decoder.
REQ-010 SHALL have port load_ack  output  1  one-cycle pulse when content is committed to the display buffer.
REQ-011 SHALL have port frame_start  output  1  one-cycle pulse in the cycle digit_pos becomes 0.

Function
REQ-012 SHALL run a dwell counter 0..DWELL-1; terminal count ("tick") wraps it to 0.
REQ-013 SHALL advance digit_pos by one on each tick, 5 wrapping to 0; values 6,7 never appear.
REQ-014 SHALL register digit and digit_pos together, so both change in the same cycle, one cycle after tick.
REQ-015 SHALL output digit = {dp_buf[pos], digit_buf[pos]} for the new position.
REQ-016 SHALL hold a pending buffer (24+6 bits plus valid flag); load captures digits_in/dp_in into it and sets valid; a later load before commit overwrites (latest wins).
REQ-017 SHALL commit pending to the display buffer only on the tick that wraps 5->0 (frame boundary), clearing valid and pulsing load_ack; no mid-frame change.
REQ-018 SHALL, when load coincides with a wrap tick, commit digits_in/dp_in directly in that cycle and leave valid clear.
REQ-019 SHALL not pulse load_ack on a wrap tick with no valid pending data and no coincident load.
REQ-020 SHALL drive frame_start in the same cycle digit_pos transitions to 0, concurrent with load_ack when a commit occurs.
REQ-021 SHALL pass BCD values 10..15 through unmodified; validity is the producer's responsibility.

Reset
REQ-022 SHALL on rst clear dwell counter, digit_pos=0, digit=5'b00000, display and pending buffers to zero, valid=0, load_ack=0, frame_start=0, blink phase=0.
REQ-023 SHALL give rst priority over load; a load asserted with rst is discarded, and pending data at rst is lost.
REQ-024 SHALL start the first dwell at position 0 the cycle after rst deasserts, without a frame_start pulse for that cycle.

Configuration
REQ-025 SHALL with macro SSEG_DP_BLINK_EN defined: force dp at positions 1 and 3 (HH.MM.SS separators) to an internal phase that toggles every CLK_HZ/2 cycles, ignoring dp_in bits 4 and 2.
REQ-026 SHALL with SSEG_DP_BLINK_EN undefined: use dp_in for all positions and contain no blink counter.

Structure
REQ-027 SHALL place NUM_DIGITS=6, BCD_W=4, position width 3 and the digit-field typedef in shared package sseg_pkg.
REQ-028 SHALL implement the dwell counter as sub-module scan_tick (parameter DWELL, outputs tick); the rest stays flat.

Verification (CLK_HZ=60, SCAN_HZ=10, DWELL=6)
REQ-029 SHALL check: rst then idle -> digit_pos 0,1,..5,0 each held 6 cycles, digit=0, frame_start every 36 cycles.
REQ-030 SHALL check: load digits_in=24'h123456, dp_in=6'b000100 mid-frame -> no output change until wrap; then load_ack pulse, positions show 1,2,3,4(dp=1),5,6.
REQ-031 SHALL check: two loads (24'h111111 then 24'h222222) in one frame -> single load_ack, display shows 2s.
REQ-032 SHALL check: load 24'h987654 in exact wrap-tick cycle -> load_ack same cycle, position 0 shows 9.
REQ-033 SHALL check: rst asserted at digit_pos=3 with pending valid -> next cycle digit_pos=0, digit=0, no load_ack at following wrap.
REQ-034 SHALL check: SSEG_DP_BLINK_EN defined, dp_in=0 -> digit[4] at positions 1,3 toggles every 30 cycles; undefined -> stays 0.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared definitions for the six-digit seven-segment scanner.
// Holds digit count, field widths, the packed digit-field type and
// a helper that picks one position out of the packed display words.
package sseg_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int BCD_W      = 4;
  localparam int POS_W      = 3;

  localparam logic [POS_W-1:0] POS_FIRST = 3'd0;
  localparam logic [POS_W-1:0] POS_LAST  = 3'd5;

  // Field driven to the external decoder: dp lit flag above the BCD nibble.
  typedef struct packed {
    logic             dp;
    logic [BCD_W-1:0] bcd;
  } digit_t;

  // Position 0 is the leftmost digit: the top nibble of the BCD word and the
  // top bit of the dp word.
  function automatic digit_t digit_at(
    input logic [NUM_DIGITS*BCD_W-1:0] bcd,
    input logic [NUM_DIGITS-1:0]       dp,
    input logic [POS_W-1:0]            pos
  );
    digit_t d;
    d = '0;
    case (pos)
      3'd0: begin d.dp = dp[5]; d.bcd = bcd[23:20]; end
      3'd1: begin d.dp = dp[4]; d.bcd = bcd[19:16]; end
      3'd2: begin d.dp = dp[3]; d.bcd = bcd[15:12]; end
      3'd3: begin d.dp = dp[2]; d.bcd = bcd[11:8];  end
      3'd4: begin d.dp = dp[1]; d.bcd = bcd[7:4];   end
      3'd5: begin d.dp = dp[0]; d.bcd = bcd[3:0];   end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sseg_scan_tick.sv
// Dwell timer for the digit scanner: counts 0..DWELL-1 and flags the
// terminal count, which also wraps the count back to 0.
module scan_tick #(
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc = (r_cnt == CNT_W'(DWELL - 1));
  assign tick = w_tc;

  // Free-running dwell count, wrapping on terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sseg_scan.sv
// Six-digit multiplexed display scanner.
// Steps through positions 0..5, holding each for DWELL cycles, and presents
// the BCD value plus dp flag of the active position to an external decoder.
// New content is staged in a pending buffer and only committed at the frame
// boundary (5 -> 0), so a frame never shows a mix of old and new digits.
// Optional build macro SSEG_DP_BLINK_EN: the dp at positions 1 and 3
// follows an internal phase toggling every CLK_HZ/2 cycles (clock
// separators); dp_in bits 4 and 2 are then ignored.
module sseg_scan
  import sseg_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int SCAN_HZ = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [NUM_DIGITS*BCD_W-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  output logic [BCD_W:0]              digit,
  output logic [POS_W-1:0]            digit_pos,
  output logic                        load_ack,
  output logic                        frame_start
);

  localparam int DWELL_RAW = CLK_HZ / SCAN_HZ;
  localparam int DWELL     = (DWELL_RAW < 2) ? 2 : DWELL_RAW;

  logic [NUM_DIGITS*BCD_W-1:0] r_disp_bcd;
  logic [NUM_DIGITS-1:0]       r_disp_dp;
  logic [NUM_DIGITS*BCD_W-1:0] r_pend_bcd;
  logic [NUM_DIGITS-1:0]       r_pend_dp;
  logic                        r_pend_vld;
  logic [POS_W-1:0]            r_pos;
  digit_t                      r_digit;
  logic                        r_load_ack;
  logic                        r_frame_start;

  logic                        w_tick;
  logic                        w_wrap;
  logic                        w_commit;
  logic [NUM_DIGITS*BCD_W-1:0] w_disp_bcd_nxt;
  logic [NUM_DIGITS-1:0]       w_disp_dp_nxt;
  logic [NUM_DIGITS-1:0]       w_dp_eff;
  logic [POS_W-1:0]            w_pos_nxt;
  digit_t                      w_digit_nxt;

  scan_tick #(
    .DWELL (DWELL)
  ) u_scan_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_wrap   = w_tick && (r_pos == POS_LAST);
  assign w_commit = w_wrap && (load || r_pend_vld);

  // Display content for the next frame: a load in the wrap cycle wins over
  // staged data, so it is shown without waiting another frame.
  always_comb begin
    w_disp_bcd_nxt = r_disp_bcd;
    w_disp_dp_nxt  = r_disp_dp;
    if (w_wrap) begin
      if (load) begin
        w_disp_bcd_nxt = digits_in;
        w_disp_dp_nxt  = dp_in;
      end else if (r_pend_vld) begin
        w_disp_bcd_nxt = r_pend_bcd;
        w_disp_dp_nxt  = r_pend_dp;
      end
    end
  end

`ifdef SSEG_DP_BLINK_EN
  localparam int HALF    = (CLK_HZ / 2 < 1) ? 1 : CLK_HZ / 2;
  localparam int BLINK_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink;

  // Separator phase: toggles once per half second of clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (r_blink_cnt == BLINK_W'(HALF - 1)) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
    end
  end

  // Positions 1 and 3 (dp bits 4 and 2) carry the separator phase.
  always_comb begin
    w_dp_eff    = w_disp_dp_nxt;
    w_dp_eff[4] = r_blink;
    w_dp_eff[2] = r_blink;
  end
`else
  // All dp bits come straight from the display buffer.
  always_comb begin
    w_dp_eff = w_disp_dp_nxt;
  end
`endif

  // Next position and the digit field it will show, both taken at a tick.
  always_comb begin
    w_pos_nxt   = w_wrap ? POS_FIRST : r_pos + POS_W'(1);
    w_digit_nxt = digit_at(w_disp_bcd_nxt, w_dp_eff, w_pos_nxt);
  end

  // Buffers, scan position and decoder outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp_bcd    <= '0;
      r_disp_dp     <= '0;
      r_pend_bcd    <= '0;
      r_pend_dp     <= '0;
      r_pend_vld    <= 1'b0;
      r_pos         <= POS_FIRST;
      r_digit       <= '0;
      r_load_ack    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_disp_bcd    <= w_disp_bcd_nxt;
      r_disp_dp     <= w_disp_dp_nxt;
      r_load_ack    <= w_commit;
      r_frame_start <= w_wrap;
      if (w_wrap) begin
        r_pend_vld <= 1'b0;
      end else if (load) begin
        r_pend_bcd <= digits_in;
        r_pend_dp  <= dp_in;
        r_pend_vld <= 1'b1;
      end
      if (w_tick) begin
        r_pos   <= w_pos_nxt;
        r_digit <= w_digit_nxt;
      end
    end
  end

  assign digit       = r_digit;
  assign digit_pos   = r_pos;
  assign load_ack    = r_load_ack;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_sseg_scan.sv
// Bench for sseg_scan at CLK_HZ=60, SCAN_HZ=10 (6-cycle dwell, 36-cycle
// frame). A cycle-indexed model derives position, frame pulses and shown
// content from the cycle number since reset; directed loads exercise
// staging, latest-wins, wrap-cycle loads and reset during a frame.
module tb_sseg_scan;

  localparam int CLK_HZ  = 60;
  localparam int SCAN_HZ = 10;
  localparam int DW      = 6;
  localparam int NPOS    = 6;
  localparam int FRAME   = DW * NPOS;
  localparam int HALF    = CLK_HZ / 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [23:0] digits_in;
  logic [5:0]  dp_in;
  logic [4:0]  digit;
  logic [2:0]  digit_pos;
  logic        load_ack;
  logic        frame_start;

  always #5 clk = ~clk;

  sseg_scan #(
    .CLK_HZ  (CLK_HZ),
    .SCAN_HZ (SCAN_HZ)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .digit       (digit),
    .digit_pos   (digit_pos),
    .load_ack    (load_ack),
    .frame_start (frame_start)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit run_cmp = 1'b0;

  // Model state: cur_n is the index of the current cycle since reset release.
  int          cur_n = 0;
  logic [23:0] m_bcd = '0;
  logic [5:0]  m_dp  = '0;
  logic [23:0] p_bcd = '0;
  logic [5:0]  p_dp  = '0;
  logic        p_vld = 1'b0;
  logic        m_ack = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cur_n);
    end
  endtask

  function automatic logic [4:0] model_digit(input int n);
    int   pos;
    int   t;
    logic dp;
    logic [3:0] bcd;
    pos = (n / DW) % NPOS;
    bcd = m_bcd[(23 - 4*pos) -: 4];
    dp  = m_dp[5 - pos];
`ifdef SSEG_DP_BLINK_EN
    if (pos == 1 || pos == 3) begin
      t  = (n / DW) * DW - 1;
      dp = ((t / HALF) % 2) == 1;
    end
`else
    t = 0;
`endif
    return {dp, bcd};
  endfunction

  // Model update: frame boundary is the last cycle of each 36-cycle frame.
  always @(posedge clk) begin
    if (rst) begin
      cur_n = 0;
      m_bcd = '0;
      m_dp  = '0;
      p_bcd = '0;
      p_dp  = '0;
      p_vld = 1'b0;
      m_ack = 1'b0;
    end else begin
      if (cur_n % FRAME == FRAME - 1) begin
        m_ack = load || p_vld;
        if (load) begin
          m_bcd = digits_in;
          m_dp  = dp_in;
        end else if (p_vld) begin
          m_bcd = p_bcd;
          m_dp  = p_dp;
        end
        p_vld = 1'b0;
      end else begin
        m_ack = 1'b0;
        if (load) begin
          p_bcd = digits_in;
          p_dp  = dp_in;
          p_vld = 1'b1;
        end
      end
      cur_n++;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("pos",   {29'd0, digit_pos},   (cur_n / DW) % NPOS);
      chk("digit", {27'd0, digit},       {27'd0, model_digit(cur_n)});
      chk("ack",   {31'd0, load_ack},    {31'd0, m_ack});
      chk("fs",    {31'd0, frame_start}, {31'd0, (cur_n != 0) && (cur_n % FRAME == 0)});
    end
  end

  task automatic wait_phase(input int ph);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((cur_n % FRAME) != ph && k < 200);
    chk("wait_phase", cur_n % FRAME, ph);
  endtask

  task automatic do_load(input logic [23:0] d, input logic [5:0] p);
    load      = 1'b1;
    digits_in = d;
    dp_in     = p;
    @(negedge clk);
    load      = 1'b0;
    digits_in = '0;
    dp_in     = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0;
    repeat (3) @(negedge clk);
    run_cmp = 1'b1;
    chk("rst_pos",   {29'd0, digit_pos},   0);
    chk("rst_digit", {27'd0, digit},       0);
    chk("rst_ack",   {31'd0, load_ack},    0);
    chk("rst_fs",    {31'd0, frame_start}, 0);

    // Load during reset is discarded.
    load = 1'b1; digits_in = 24'h777777; dp_in = 6'h3F;
    @(negedge clk);
    rst = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0;

    // Idle scanning.
    repeat (36) @(negedge clk);
    chk("idle_fs",    {31'd0, frame_start}, 1);
    chk("idle_pos",   {29'd0, digit_pos},   0);
    chk("idle_ack",   {31'd0, load_ack},    0);
    chk("idle_digit", {27'd0, digit},       0);
    repeat (45) @(negedge clk);

    // Mid-frame load shows only after the wrap.
    wait_phase(10);
    do_load(24'h123456, 6'b000100);
    wait_phase(0);
    chk("l1_ack",   {31'd0, load_ack}, 1);
    chk("l1_pos0",  {27'd0, digit},    5'h01);
    wait_phase(18);
`ifndef SSEG_DP_BLINK_EN
    chk("l1_pos3",  {27'd0, digit},    5'h14);
`endif
    wait_phase(30);
    chk("l1_pos5",  {27'd0, digit},    5'h06);
    wait_phase(0);
    chk("l1_noack", {31'd0, load_ack}, 0);

    // Two loads in one frame: latest wins, single ack.
    wait_phase(5);
    do_load(24'h111111, 6'b000000);
    wait_phase(20);
    do_load(24'h222222, 6'b000000);
    wait_phase(0);
    chk("l2_ack",   {31'd0, load_ack}, 1);
    chk("l2_digit", {27'd0, digit},    5'h02);
    @(negedge clk);
    chk("l2_ack_one", {31'd0, load_ack}, 0);

    // Load in the exact wrap-tick cycle commits at once.
    wait_phase(35);
    do_load(24'h987654, 6'b000000);
    chk("wrap_ack",   {31'd0, load_ack},    1);
    chk("wrap_fs",    {31'd0, frame_start}, 1);
    chk("wrap_digit", {27'd0, digit},       5'h09);

    // BCD 10..15 pass through untouched.
    wait_phase(2);
    do_load(24'hABCDEF, 6'b101010);
    wait_phase(0);
    chk("hex_pos0", {27'd0, digit}, 5'h1A);
    wait_phase(12);
    chk("hex_pos2", {27'd0, digit}, 5'h1C);
    wait_phase(24);
    chk("hex_pos4", {27'd0, digit}, 5'h1E);

    // Reset at position 3 with pending data loses the data.
    wait_phase(3);
    do_load(24'h555555, 6'b111111);
    wait_phase(19);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst3_pos",   {29'd0, digit_pos}, 0);
    chk("rst3_digit", {27'd0, digit},     0);
    repeat (36) @(negedge clk);
    chk("rst3_fs",    {31'd0, frame_start}, 1);
    chk("rst3_noack", {31'd0, load_ack},    0);
    chk("rst3_dig",   {27'd0, digit},       0);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
